// File: rtl/text_overlay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : text_overlay_ctrl
//  Description : Draws a ROWS x COLS character text box over the VGA stream.
//                It addresses the message ROM from the pixel counters, turns
//                the returned character code into a font ROM address, picks
//                the font bit for the current pixel and keys TEXT_RGB over the
//                upstream colour. A frame-synchronous show/blink state machine
//                gates the overlay so it never changes mid-frame.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                      pixel clock
//    rst_n                    asynchronous active-low reset
//    hcount_in / vcount_in    pixel position (11 bit)
//    hsync_in / vsync_in      sync inputs
//    hblnk_in / vblnk_in      blanking inputs
//    rgb_in                   upstream colour (12 bit)
//    show                     level request to display the text
//    char_yx                  message ROM address {row[3:0], col[3:0]}
//    char_code                message ROM data, 1 clk after char_yx
//    font_addr                font ROM address {char_code[6:0], line[3:0]}
//    font_pixels              font ROM data, 1 clk after font_addr, MSB left
//    hcount_out / vcount_out  counters delayed 5 clocks
//    hsync_out / vsync_out    syncs delayed 5 clocks
//    hblnk_out / vblnk_out    blanking delayed 5 clocks
//    rgb_out                  output colour, 5 clocks after the pixel
// ============================================================================
module text_overlay_ctrl #(
    parameter int          XPOS         = 336,
    parameter int          YPOS         = 300,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 2,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] TEXT_RGB     = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        show,
    output logic [7:0]  char_yx,
    input  logic [7:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [11:0] c_XPOS  = 12'(XPOS);
    localparam logic [11:0] c_YPOS  = 12'(YPOS);
    localparam logic [11:0] c_BOX_W = 12'(COLS * 8);
    localparam logic [11:0] c_BOX_H = 12'(ROWS * 16);

    localparam bit          c_BLINK_EN   = (BLINK_FRAMES != 0);
    localparam logic [7:0]  c_BLINK_LAST = 8'((BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1);

    // Side-band vector carried down the pipeline:
    // {hcount[37:27], vcount[26:16], hsync[15], vsync[14], hblnk[13], vblnk[12], rgb[11:0]}
    localparam int c_SIDE_W  = 38;
    localparam int c_B_HBLNK = 13;
    localparam int c_B_VBLNK = 12;

    // Per-pixel control carried to stage 5: {draw_en, in_box, xoff[2:0]}
    localparam int c_CTL_W = 5;

    // ------------------------------------------------------------------------
    // Show/blink state machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_HIDDEN = 2'd0,
        ST_ON     = 2'd1,
        ST_OFF    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        vblnk_prev_q;
    logic        w_frame_evt;
    logic [7:0]  w_cnt_inc;
    logic        w_draw_en;

    // A frame event is the rising edge of vblnk_in; since it always falls in
    // vertical blanking, the overlay state can only change between frames.
    assign w_frame_evt = vblnk_in & ~vblnk_prev_q;
    assign w_cnt_inc   = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
    assign w_draw_en   = (state_q == ST_ON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HIDDEN;
            frame_cnt_q  <= 8'd0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            vblnk_prev_q <= vblnk_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (w_frame_evt) begin
            case (state_q)
                ST_HIDDEN: begin
                    if (show) begin
                        state_d     = ST_ON;
                        frame_cnt_d = 8'd0;
                    end
                end
                ST_ON: begin
                    if (!show) begin
                        state_d = ST_HIDDEN;
                    end else if (c_BLINK_EN && (frame_cnt_q == c_BLINK_LAST)) begin
                        state_d     = ST_OFF;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = w_cnt_inc;
                    end
                end
                ST_OFF: begin
                    if (!show) begin
                        state_d = ST_HIDDEN;
                    end else if (frame_cnt_q == c_BLINK_LAST) begin
                        state_d     = ST_ON;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    state_d     = ST_HIDDEN;
                    frame_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 address generation
    // ------------------------------------------------------------------------
    logic [11:0] w_relx;
    logic [11:0] w_rely;
    logic        w_in_box;

    assign w_relx = {1'b0, hcount_in} - c_XPOS;
    assign w_rely = {1'b0, vcount_in} - c_YPOS;

    // Negative offsets wrap to values >= 2048 in 12 bits, far above any legal
    // box size, so one unsigned compare rejects both sides of each axis.
    assign w_in_box = (w_relx < c_BOX_W) && (w_rely < c_BOX_H);

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic [c_SIDE_W-1:0] w_side_in;
    logic [c_SIDE_W-1:0] side_q [1:4];
    logic [c_CTL_W-1:0]  ctl_q  [1:4];
    logic [7:0]          char_yx_q;
    logic [3:0]          line1_q;
    logic [3:0]          line2_q;
    logic [10:0]         font_addr_q;
    logic [25:0]         tim_out_q;
    logic [11:0]         rgb_out_q;

    assign w_side_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

    // Stage 4 view: font_pixels belongs to the pixel held in side_q[4]/ctl_q[4]
    logic       w_s4_blank;
    logic       w_s4_draw;
    logic       w_s4_in_box;
    logic [2:0] w_s4_xoff;
    logic       w_font_bit;
    logic       w_text_px;

    assign w_s4_blank  = side_q[4][c_B_HBLNK] | side_q[4][c_B_VBLNK];
    assign w_s4_draw   = ctl_q[4][4];
    assign w_s4_in_box = ctl_q[4][3];
    assign w_s4_xoff   = ctl_q[4][2:0];
    assign w_font_bit  = font_pixels[3'd7 - w_s4_xoff];
    assign w_text_px   = w_s4_draw & w_s4_in_box & ~w_s4_blank & w_font_bit;

    // The ROM ignores bit 7 of the character code; tie it off explicitly.
    logic w_unused_code_msb;
    assign w_unused_code_msb = char_code[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_yx_q   <= 8'h00;
            line1_q     <= 4'd0;
            line2_q     <= 4'd0;
            font_addr_q <= 11'd0;
            for (int i = 1; i <= 4; i++) begin
                side_q[i] <= '0;
                ctl_q[i]  <= '0;
            end
            tim_out_q   <= '0;
            rgb_out_q   <= 12'h000;
        end else begin
            // Stage 1: message ROM address and per-pixel control
            char_yx_q <= w_in_box ? {w_rely[7:4], w_relx[6:3]} : 8'h00;
            line1_q   <= w_rely[3:0];
            side_q[1] <= w_side_in;
            // draw_en is sampled with the pixel so every pixel of a frame sees
            // the same overlay state regardless of pipeline position.
            ctl_q[1]  <= {w_draw_en, w_in_box, w_relx[2:0]};

            // Stage 2: char_code arrives from the ROM; only re-time the line
            line2_q <= line1_q;

            // Stage 3: font address
            font_addr_q <= {char_code[6:0], line2_q};

            for (int i = 2; i <= 4; i++) begin
                side_q[i] <= side_q[i-1];
                ctl_q[i]  <= ctl_q[i-1];
            end

            // Stage 5: colour key and output timing
            tim_out_q <= side_q[4][c_SIDE_W-1:12];
            rgb_out_q <= w_text_px ? TEXT_RGB : side_q[4][11:0];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign char_yx   = char_yx_q;
    assign font_addr = font_addr_q;
    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_out_q;
    assign rgb_out   = rgb_out_q;

endmodule
`default_nettype wire

// File: tb/tb_text_overlay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_overlay_ctrl
//  Description : Self-checking bench for text_overlay_ctrl. Emulates the
//                registered message and font ROMs, keeps a pixel-level model
//                of the expected outputs and runs directed probes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_overlay_ctrl;

    localparam int          XPOS = 336;
    localparam int          YPOS = 300;
    localparam int          COLS = 16;
    localparam int          ROWS = 2;
    localparam int          BF   = 3;
    localparam logic [11:0] TXT  = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        show = 1'b0;
    logic [7:0]  char_yx;
    logic [7:0]  char_code = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_pixels = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_chk  = 0;
    int n_fail = 0;

    text_overlay_ctrl #(
        .XPOS(XPOS), .YPOS(YPOS), .COLS(COLS), .ROWS(ROWS),
        .BLINK_FRAMES(BF), .TEXT_RGB(TXT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .show(show),
        .char_yx(char_yx), .char_code(char_code),
        .font_addr(font_addr), .font_pixels(font_pixels),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // ROM contents (bit 7 set on most codes to show it is ignored)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] msg_rom(input logic [7:0] a);
        if (a == 8'h13) return 8'h52;
        return 8'h80 | 8'((a * 13) ^ 8'h35);
    endfunction

    function automatic logic [7:0] font_rom(input logic [10:0] a);
        if (a == 11'h525) return 8'b0010_0000;
        return 8'((a * 29) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        char_code   <= msg_rom(char_yx);
        font_pixels <= font_rom(font_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: expected outputs per pixel, aged through a 5-deep queue
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
        logic [7:0]  yx;
        logic [10:0] fa;
        logic        fa_ok;
    } rec_t;

    rec_t pipe [5];
    bit   m_shown, m_dark, m_vb_prev;
    int   m_frames;

    always @(posedge clk) begin
        rec_t       r;
        int         relx, rely, xo;
        bit         inb;
        logic [7:0] cc, fp;
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) pipe[i] = '0;
            m_shown = 0; m_dark = 0; m_frames = 0; m_vb_prev = 0;
        end else begin
            relx = int'(hcount_in) - XPOS;
            rely = int'(vcount_in) - YPOS;
            inb  = (relx >= 0) && (relx < COLS * 8) && (rely >= 0) && (rely < ROWS * 16);
            xo   = relx & 7;
            r.hc = hcount_in; r.vc = vcount_in;
            r.hs = hsync_in;  r.vs = vsync_in; r.hb = hblnk_in; r.vb = vblnk_in;
            r.yx = inb ? 8'((rely / 16) * 16 + relx / 8) : 8'h00;
            cc   = msg_rom(r.yx);
            r.fa = 11'((cc % 128) * 16 + (rely & 15));
            r.fa_ok = 1'b1;
            fp   = font_rom(r.fa);
            r.rgb = (m_shown && !m_dark && inb && !hblnk_in && !vblnk_in && fp[7 - xo])
                    ? TXT : rgb_in;
            for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = r;
            // overlay visibility only changes at a vblank rising edge
            if (vblnk_in && !m_vb_prev) begin
                if (!m_shown) begin
                    if (show) begin m_shown = 1; m_dark = 0; m_frames = 0; end
                end else if (!show) begin
                    m_shown = 0;
                end else if (BF != 0 && m_frames == BF - 1) begin
                    m_dark = !m_dark; m_frames = 0;
                end else if (m_frames < 255) begin
                    m_frames++;
                end
            end
            m_vb_prev = vblnk_in;
        end
        #2;
        check("char_yx", char_yx, pipe[0].yx);
        if (!rst_n)             check("font_addr_rst", font_addr, 0);
        else if (pipe[2].fa_ok) check("font_addr", font_addr, pipe[2].fa);
        check("hcount_out", hcount_out, pipe[4].hc);
        check("vcount_out", vcount_out, pipe[4].vc);
        check("hsync_out",  hsync_out,  pipe[4].hs);
        check("vsync_out",  vsync_out,  pipe[4].vs);
        check("hblnk_out",  hblnk_out,  pipe[4].hb);
        check("vblnk_out",  vblnk_out,  pipe[4].vb);
        check("rgb_out",    rgb_out,    pipe[4].rgb);
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic vb, input logic hs, input logic vs, input logic [11:0] c);
        @(negedge clk);
        hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb;
        hsync_in = hs; vsync_in = vs; rgb_in = c;
    endtask

    task automatic frame_evt();
        drive(11'd0, 11'd610, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
        drive(11'd0, 11'd611, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
        drive(11'd0, 11'd0,   1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    // One-pixel probe followed by filler; checks at t+1, t+3 and t+5.
    task automatic probe(input string nm, input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] c, input logic [7:0] exp_yx,
                         input bit chk_fa, input logic [10:0] exp_fa,
                         input logic [11:0] exp_rgb);
        drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0, c);
        @(posedge clk); #2;
        check({nm, "_yx"}, char_yx, exp_yx);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(posedge clk);
        @(posedge clk); #2;
        if (chk_fa) check({nm, "_fa"}, font_addr, exp_fa);
        @(posedge clk);
        @(posedge clk); #2;
        check({nm, "_rgb"}, rgb_out, exp_rgb);
    endtask

    bit exp_on [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++)
            drive(11'($urandom_range(330, 470)), 11'($urandom_range(295, 335)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  12'($urandom));
        #1;
        check("rst_rgb_out", rgb_out, 0);
        check("rst_hcount_out", hcount_out, 0);
        check("rst_char_yx", char_yx, 0);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        rst_n = 1'b1;
        show  = 1'b1;
        repeat (3) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        frame_evt();   // e1: HIDDEN -> ON

        // Address generation and pixel select
        probe("addr_362_321", 11'd362, 11'd321, 12'h123, 8'h13, 1'b1, 11'h525, TXT);
        probe("xoff3_pass",   11'd363, 11'd321, 12'h234, 8'h13, 1'b1, 11'h525, 12'h234);
        probe("corner_x1",    11'd337, 11'd300, 12'h345, 8'h00, 1'b1, 11'h350, TXT);
        probe("corner_x0",    11'd336, 11'd300, 12'h456, 8'h00, 1'b1, 11'h350, 12'h456);
        probe("last_char",    11'd463, 11'd331, 12'hABC, 8'h1F, 1'b1, 11'h26F, 12'hABC);

        // Boundaries outside the box
        probe("left_335",  11'd335, 11'd321, 12'h567, 8'h00, 1'b0, 11'h000, 12'h567);
        probe("right_464", 11'd464, 11'd321, 12'h678, 8'h00, 1'b0, 11'h000, 12'h678);
        probe("below_332", 11'd362, 11'd332, 12'h789, 8'h00, 1'b0, 11'h000, 12'h789);
        probe("above_299", 11'd362, 11'd299, 12'h89A, 8'h00, 1'b0, 11'h000, 12'h89A);

        // Blink: after e2..e7 the overlay is ON,ON,OFF,OFF,OFF,ON
        for (int i = 0; i < 6; i++) begin
            frame_evt();
            probe("blink", 11'd362, 11'd321, 12'h123, 8'h13, 1'b1, 11'h525,
                  exp_on[i] ? TXT : 12'h123);
        end

        // Dropping show mid-frame only takes effect at the next frame event
        show = 1'b0;
        probe("show_drop_midframe", 11'd362, 11'd321, 12'h123, 8'h13, 1'b0, 11'h000, TXT);
        frame_evt();
        probe("hidden", 11'd362, 11'd321, 12'h123, 8'h13, 1'b0, 11'h000, 12'h123);
        show = 1'b1;
        probe("show_pulse_midframe", 11'd362, 11'd321, 12'h123, 8'h13, 1'b0, 11'h000, 12'h123);
        show = 1'b0;
        frame_evt();
        probe("still_hidden", 11'd362, 11'd321, 12'h123, 8'h13, 1'b0, 11'h000, 12'h123);
        show = 1'b1;
        frame_evt();

        // Random timing/pixel traffic around the box
        for (int i = 0; i < 300; i++)
            drive(11'($urandom_range(320, 480)), 11'($urandom_range(290, 340)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom), 1'($urandom), 12'($urandom));

        // Reset mid-frame while text is being drawn
        frame_evt();
        frame_evt();
        frame_evt();
        frame_evt();   // ensure blink phase: compute nothing, just stream
        for (int i = 0; i < 8; i++)
            drive(11'd362, 11'd321, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rgb_out", rgb_out, 0);
        check("midrst_hcount_out", hcount_out, 0);
        check("midrst_font_addr", font_addr, 0);
        check("midrst_char_yx", char_yx, 0);
        repeat (2) drive(11'd362, 11'd321, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        rst_n = 1'b1;
        repeat (8) drive(11'd362, 11'd321, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        #1;
        check("post_rst_no_text", rgb_out, 12'h456);
        repeat (4) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
